// File: rtl/alu_rr_arbiter_if.sv
// Request/response channel between one requester and the shared-ALU arbiter.
// The master side issues ALU requests and consumes responses.
// The slave side is the arbiter.
interface alu_rr_arbiter_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [DATA_WIDTH-1:0] req_a;
   logic [DATA_WIDTH-1:0] req_b;
   logic [2:0]            req_op;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_result;
   logic [2:0]            rsp_flags;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_flags
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_flags
   );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Two-port round-robin arbiter in front of one shared 32-bit ALU.
// ALU ops: AND/OR/ADD/SUB/SLT. Flags are {Overflow, CarryOut, Zero}.
// Optional macro ALU_ARB_PERF_EN adds per-port accepted-request counters.
// When the macro is not defined, grant_cnt0 and grant_cnt1 read 0.
//
// state  | meaning
// S_IDLE | arbitrate; the granted port sees ready and its operands are latched
// S_EXEC | ALU runs on the latched operands; result/flags are captured
// S_RESP | response held for the granted port until its rsp_ready
module alu_rr_arbiter #(
   parameter int DATA_WIDTH = 32
) (
   input  logic               clk,
   input  logic               resetn,
   alu_rr_arbiter_if.slave    port0,
   alu_rr_arbiter_if.slave    port1,
   output logic               busy,
   output logic [31:0]        grant_cnt0,
   output logic [31:0]        grant_cnt1
);
   localparam int MSB = DATA_WIDTH - 1;
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t                state;
   logic                  last_grant;
   logic                  grant_id;
   logic [DATA_WIDTH-1:0] opa;
   logic [DATA_WIDTH-1:0] opb;
   logic [2:0]            op_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic [2:0]            flags_q;
   logic                  rsp0_valid_q;
   logic                  rsp1_valid_q;

   logic any_valid;
   logic sel;

   // On a tie the grant goes to the port that did not win last time.
   assign any_valid = port0.req_valid | port1.req_valid;
   assign sel       = (port0.req_valid && port1.req_valid) ? ~last_grant : port1.req_valid;

   assign port0.req_ready = (state == S_IDLE) && any_valid && !sel;
   assign port1.req_ready = (state == S_IDLE) && any_valid && sel;

   assign port0.rsp_valid  = rsp0_valid_q;
   assign port1.rsp_valid  = rsp1_valid_q;
   assign port0.rsp_result = result_q;
   assign port1.rsp_result = result_q;
   assign port0.rsp_flags  = flags_q;
   assign port1.rsp_flags  = flags_q;
   assign busy             = (state != S_IDLE);

   logic                  binv;
   logic [DATA_WIDTH-1:0] b_eff;
   logic [DATA_WIDTH:0]   sum_ext;
   logic [DATA_WIDTH-1:0] sum;
   logic                  ovf_arith;
   logic                  slt;
   logic [DATA_WIDTH-1:0] alu_result;
   logic                  alu_ovf;
   logic                  alu_cout;
   logic                  alu_zero;

   // Shared ALU, fed only from the latched operand registers.
   // Undefined ops use the uninverted add path for CarryOut.
   // SUB/SLT report borrow on CarryOut.
   always_comb begin
      binv      = (op_q == OP_SUB) || (op_q == OP_SLT);
      b_eff     = binv ? ~opb : opb;
      sum_ext   = {1'b0, opa} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, binv};
      sum       = sum_ext[MSB:0];
      ovf_arith = (opa[MSB] == b_eff[MSB]) && (sum[MSB] != opa[MSB]);
      slt       = sum[MSB] ^ ovf_arith;
      alu_cout  = binv ? ~sum_ext[DATA_WIDTH] : sum_ext[DATA_WIDTH];
      alu_ovf   = 1'b0;
      case (op_q)
         OP_AND:  alu_result = opa & opb;
         OP_OR:   alu_result = opa | opb;
         OP_ADD:  begin alu_result = sum; alu_ovf = ovf_arith; end
         OP_SUB:  begin alu_result = sum; alu_ovf = ovf_arith; end
         OP_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}}, slt};
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   // Control FSM with registered operands, results and response valids.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= S_IDLE;
         last_grant   <= 1'b1;
         grant_id     <= 1'b0;
         opa          <= '0;
         opb          <= '0;
         op_q         <= '0;
         result_q     <= '0;
         flags_q      <= '0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_valid) begin
                  grant_id   <= sel;
                  last_grant <= sel;
                  opa        <= sel ? port1.req_a  : port0.req_a;
                  opb        <= sel ? port1.req_b  : port0.req_b;
                  op_q       <= sel ? port1.req_op : port0.req_op;
                  state      <= S_EXEC;
               end
            end
            S_EXEC: begin
               result_q     <= alu_result;
               flags_q      <= {alu_ovf, alu_cout, alu_zero};
               rsp0_valid_q <= !grant_id;
               rsp1_valid_q <= grant_id;
               state        <= S_RESP;
            end
            S_RESP: begin
               if ((!grant_id && port0.rsp_ready) || (grant_id && port1.rsp_ready)) begin
                  rsp0_valid_q <= 1'b0;
                  rsp1_valid_q <= 1'b0;
                  state        <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef ALU_ARB_PERF_EN
   logic [31:0] cnt0_q;
   logic [31:0] cnt1_q;

   // Accepted-request counters; they wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (port0.req_valid && port0.req_ready) cnt0_q <= cnt0_q + 32'd1;
         if (port1.req_valid && port1.req_ready) cnt1_q <= cnt1_q + 32'd1;
      end
   end

   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;
`else
   assign grant_cnt0 = 32'b0;
   assign grant_cnt1 = 32'b0;
`endif
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: tie-breaking, ALU results/flags,
// backpressure, mid-transaction reset, undefined op, and counters.
module tb_alu_rr_arbiter;
   logic        clk = 1'b0;
   logic        resetn;
   logic        busy;
   logic [31:0] gc0;
   logic [31:0] gc1;
   int          n_checks = 0;
   int          n_fail = 0;

`ifdef ALU_ARB_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   always #5 clk = ~clk;

   alu_rr_arbiter_if #(.DATA_WIDTH(32)) p0 ();
   alu_rr_arbiter_if #(.DATA_WIDTH(32)) p1 ();

   alu_rr_arbiter #(.DATA_WIDTH(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .port0      (p0),
      .port1      (p1),
      .busy       (busy),
      .grant_cnt0 (gc0),
      .grant_cnt1 (gc1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic req0(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      p0.req_valid = v; p0.req_op = op; p0.req_a = a; p0.req_b = b;
   endtask

   task automatic req1(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      p1.req_valid = v; p1.req_op = op; p1.req_a = a; p1.req_b = b;
   endtask

   // Called at the negedge in EXEC: checks the response in RESP, then consumes it.
   task automatic finish_rsp(input string tag, input bit port, input logic [31:0] res, input logic [2:0] flg);
      tick();
      chk({tag, "_valid"}, port ? p1.rsp_valid : p0.rsp_valid, 1'b1);
      chk({tag, "_other"}, port ? p0.rsp_valid : p1.rsp_valid, 1'b0);
      chk({tag, "_result"}, port ? p1.rsp_result : p0.rsp_result, res);
      chk({tag, "_flags"}, {29'd0, port ? p1.rsp_flags : p0.rsp_flags}, {29'd0, flg});
      if (port) p1.rsp_ready = 1'b1; else p0.rsp_ready = 1'b1;
      tick();
      p0.rsp_ready = 1'b0;
      p1.rsp_ready = 1'b0;
      chk({tag, "_drop"}, port ? p1.rsp_valid : p0.rsp_valid, 1'b0);
      chk({tag, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      resetn = 1'b0;
      req0(1'b0, 3'b000, 32'd0, 32'd0);
      req1(1'b0, 3'b000, 32'd0, 32'd0);
      p0.rsp_ready = 1'b0;
      p1.rsp_ready = 1'b0;
      tick(); tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp0_valid", p0.rsp_valid, 1'b0);
      chk("rst_rsp1_valid", p1.rsp_valid, 1'b0);
      chk("rst_result", p0.rsp_result, 32'd0);
      chk("rst_flags", {29'd0, p0.rsp_flags}, 32'd0);
      chk("rst_cnt0", gc0, 32'd0);
      chk("rst_cnt1", gc1, 32'd0);
      resetn = 1'b1;
      tick();

      // Tie straight out of reset: port 0 first.
      req0(1'b1, 3'b110, 32'd5, 32'd5);
      req1(1'b1, 3'b001, 32'h0000_00F0, 32'h0000_000F);
      #1;
      chk("tie1_ready0", p0.req_ready, 1'b1);
      chk("tie1_ready1", p1.req_ready, 1'b0);
      tick();
      req0(1'b0, 3'b000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      #1;
      chk("tie1_exec_busy", busy, 1'b1);
      chk("tie1_exec_rsp0", p0.rsp_valid, 1'b0);
      chk("tie1_exec_ready1", p1.req_ready, 1'b0);
      finish_rsp("sub_5_5", 1'b0, 32'd0, 3'b001);
      #1;
      chk("tie1_then_ready1", p1.req_ready, 1'b1);
      tick();
      req1(1'b0, 3'b000, 32'd0, 32'd0);
      finish_rsp("or_f0_0f", 1'b1, 32'h0000_00FF, 3'b000);

      // Second tie: port 1 won last, so port 0 goes first.
      req0(1'b1, 3'b000, 32'h0000_FF00, 32'h0000_0FF0);
      req1(1'b1, 3'b010, 32'd1, 32'd2);
      #1;
      chk("tie2_ready0", p0.req_ready, 1'b1);
      chk("tie2_ready1", p1.req_ready, 1'b0);
      tick();
      req0(1'b0, 3'b000, 32'd0, 32'd0);
      finish_rsp("and_tie2", 1'b0, 32'h0000_0F00, 3'b000);
      tick();
      req1(1'b0, 3'b000, 32'd0, 32'd0);
      finish_rsp("add_1_2", 1'b1, 32'd3, 3'b000);

      // Single request with signed overflow on ADD.
      req0(1'b1, 3'b010, 32'h7FFF_FFFF, 32'd1);
      tick();
      req0(1'b0, 3'b000, 32'd0, 32'd0);
      chk("add_ovf_exec_rsp1", p1.rsp_valid, 1'b0);
      finish_rsp("add_ovf", 1'b0, 32'h8000_0000, 3'b100);

      // Backpressure on port 1 SLT while port 0 waits.
      req0(1'b1, 3'b001, 32'd1, 32'd2);
      req1(1'b1, 3'b111, 32'hFFFF_FFFF, 32'd1);
      #1;
      chk("bp_ready1", p1.req_ready, 1'b1);
      chk("bp_ready0", p0.req_ready, 1'b0);
      tick();
      req1(1'b0, 3'b000, 32'd0, 32'd0);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp1_valid", p1.rsp_valid, 1'b1);
         chk("bp_rsp1_result", p1.rsp_result, 32'd1);
         chk("bp_rsp1_flags", {29'd0, p1.rsp_flags}, 32'd0);
         chk("bp_req0_ready", p0.req_ready, 1'b0);
         chk("bp_busy", busy, 1'b1);
         tick();
      end
      p1.rsp_ready = 1'b1;
      tick();
      p1.rsp_ready = 1'b0;
      chk("bp_rsp1_drop", p1.rsp_valid, 1'b0);
      #1;
      chk("bp_req0_ready_after", p0.req_ready, 1'b1);
      tick();
      req0(1'b0, 3'b000, 32'd0, 32'd0);
      finish_rsp("or_1_2", 1'b0, 32'd3, 3'b000);

      // Undefined op 100 on port 1.
      req1(1'b1, 3'b100, 32'd3, 32'd3);
      tick();
      req1(1'b0, 3'b000, 32'd0, 32'd0);
      finish_rsp("undef_op", 1'b1, 32'd0, 3'b001);

      chk("cnt0", gc0, PERF ? 32'd4 : 32'd0);
      chk("cnt1", gc1, PERF ? 32'd4 : 32'd0);

      // Reset while in EXEC discards the transaction.
      req0(1'b1, 3'b010, 32'd1, 32'd1);
      tick();
      req0(1'b0, 3'b000, 32'd0, 32'd0);
      chk("mid_exec_busy", busy, 1'b1);
      resetn = 1'b0;
      tick();
      chk("mid_rst_rsp0", p0.rsp_valid, 1'b0);
      chk("mid_rst_rsp1", p1.rsp_valid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_cnt0", gc0, 32'd0);
      resetn = 1'b1;
      tick();
      chk("post_rst_rsp0", p0.rsp_valid, 1'b0);
      req0(1'b1, 3'b110, 32'd9, 32'd4);
      req1(1'b1, 3'b000, 32'd7, 32'd7);
      #1;
      chk("post_rst_ready0", p0.req_ready, 1'b1);
      chk("post_rst_ready1", p1.req_ready, 1'b0);
      tick();
      req0(1'b0, 3'b000, 32'd0, 32'd0);
      req1(1'b0, 3'b000, 32'd0, 32'd0);
      finish_rsp("sub_9_4", 1'b0, 32'd5, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
